// File: rtl/watch_display_scan.sv
// Four-digit multiplexed seven-segment driver for the watch time bus.
// Scans one digit per refresh slot and shows a per-frame snapshot of hr1/hr0/min1/min0.
module watch_display_scan #(
    parameter int REFRESH_DIV = 1000,
    parameter int BLINK_DIV   = 250000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] hr1,
    input  logic [3:0] hr0,
    input  logic [3:0] min1,
    input  logic [3:0] min0,
    input  logic       colon_en,
    input  logic [3:0] blink_mask,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp_n,
    output logic       frame_done
);

    localparam int SLOT_W  = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [SLOT_W-1:0]  slot_cnt;
    logic [1:0]         digit_idx;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;
    logic [15:0]        snapshot;

    logic       slot_wrap;
    logic       frame_end;
    logic       blink_wrap;
    logic [3:0] cur_digit;
    logic       blank;
    logic [3:0] an_d;
    logic [6:0] seg_d;
    logic       dp_d;

    assign slot_wrap  = (slot_cnt == SLOT_LAST);
    assign frame_end  = slot_wrap && (digit_idx == 2'd3);
    assign blink_wrap = (blink_cnt == BLINK_LAST);

    function automatic logic [6:0] decode(input logic [3:0] value);
        logic [6:0] pattern;
        case (value)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            default: pattern = 7'b0111111;
        endcase
        return pattern;
    endfunction

    // Digit select from the frozen snapshot, never from the live bus.
    always_comb begin
        cur_digit = 4'd0;
        case (digit_idx)
            2'd0: cur_digit = snapshot[3:0];
            2'd1: cur_digit = snapshot[7:4];
            2'd2: cur_digit = snapshot[11:8];
            2'd3: cur_digit = snapshot[15:12];
            default: cur_digit = 4'd0;
        endcase
    end

    always_comb begin
        blank = ((digit_idx == 2'd3) && (snapshot[15:12] == 4'd0))
             || (blink_mask[digit_idx] && blink_phase);
        an_d  = 4'b1111;
        seg_d = 7'b1111111;
        dp_d  = 1'b1;
        if (!blank) begin
            an_d[digit_idx] = 1'b0;
            seg_d           = decode(cur_digit);
            dp_d            = !(colon_en && (digit_idx == 2'd2));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt    <= '0;
            digit_idx   <= 2'd0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            snapshot    <= 16'h0000;
            frame_done  <= 1'b0;
            an          <= 4'b1111;
            seg         <= 7'b1111111;
            dp_n        <= 1'b1;
        end else begin
            slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
            if (slot_wrap) begin
                digit_idx <= digit_idx + 2'd1;
            end
            // Blink timebase is independent of the scan; both may fire on one edge.
            blink_cnt <= blink_wrap ? '0 : blink_cnt + 1'b1;
            if (blink_wrap) begin
                blink_phase <= !blink_phase;
            end
            if (frame_end) begin
                snapshot <= {hr1, hr0, min1, min0};
            end
            frame_done <= frame_end;
            an         <= an_d;
            seg        <= seg_d;
            dp_n       <= dp_d;
        end
    end

endmodule

// File: tb/tb_watch_display_scan.sv
// Directed plus randomized bench for watch_display_scan against a cycle-count model.
module tb_watch_display_scan;

    localparam int R = 4;
    localparam int B = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] hr1 = 4'd1, hr0 = 4'd2, min1 = 4'd3, min0 = 4'd4;
    logic       colon_en = 1'b0;
    logic [3:0] blink_mask = 4'b0000;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp_n;
    logic       frame_done;

    watch_display_scan #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
        .clk(clk), .reset(reset),
        .hr1(hr1), .hr0(hr0), .min1(min1), .min0(min0),
        .colon_en(colon_en), .blink_mask(blink_mask),
        .an(an), .seg(seg), .dp_n(dp_n), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Model: n = clock edges since reset released; snapshots latched at frame ends.
    int          n = 0;
    logic [15:0] exp_q[$];
    logic [3:0]  e_an = 4'b1111;
    logic [6:0]  e_seg = 7'b1111111;
    logic        e_dp = 1'b1;
    logic        e_fd = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          n_fail = 0;

    logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                  7'b0000000, 7'b0010000};

    function automatic logic [15:0] model_snap();
        return (exp_q.size() == 0) ? 16'h0000 : exp_q[$];
    endfunction

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b (n=%0d)", tag, obs, exp, n);
        end
    endtask

    task automatic tick();
        int          idx;
        int          phase;
        int          digit;
        bit          blank;
        logic [15:0] snap;
        @(posedge clk);
        if (reset) begin
            n = 0;
            exp_q.delete();
            e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1; e_fd = 1'b0;
        end else begin
            idx   = (n / R) % 4;
            phase = (n / B) % 2;
            snap  = model_snap();
            digit = int'((snap >> (4 * idx)) & 16'hF);
            blank = (idx == 3 && digit == 0) || (blink_mask[idx] && phase == 1);
            if (blank) begin
                e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1;
            end else begin
                e_an  = ~(4'b0001 << idx);
                e_seg = (digit <= 9) ? seg_tab[digit] : 7'b0111111;
                e_dp  = !(colon_en && idx == 2);
            end
            e_fd = ((n + 1) % (4 * R) == 0);
            if (e_fd) exp_q.push_back({hr1, hr0, min1, min0});
            n++;
        end
        #1;
        check("an", 7'(an), 7'(e_an));
        check("seg", seg, e_seg);
        check("dp_n", 7'(dp_n), 7'(e_dp));
        check("frame_done", 7'(frame_done), 7'(e_fd));
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) tick();
    endtask

    initial begin
        // Reset with live inputs 1,2,3,4: first frame must still show zeros.
        reset = 1'b1;
        run(2);
        check("reset_an", 7'(an), 7'b0001111);
        check("reset_seg", seg, 7'b1111111);
        reset = 1'b0;
        tick();
        check("first_an", 7'(an), 7'b0001110);
        check("first_seg", seg, 7'b1000000);
        run(4 * R - 1);
        run(4 * R);
        // Third frame: min0 changes mid-frame, visible only from the next frame.
        run(R + 2);
        min0 = 4'd5;
        run(3 * R - 2);
        run(4 * R);
        // Colon on for a frame, then off.
        colon_en = 1'b1;
        run(4 * R);
        colon_en = 1'b0;
        run(4 * R);
        // Blinking on min0/min1 across several blink half-periods.
        blink_mask = 4'b0011;
        run(6 * B);
        blink_mask = 4'b0000;
        // Out-of-range hr0 presented across a frame boundary shows a dash.
        hr0 = 4'hC;
        run(8 * R);
        hr0 = 4'd2;
        // Reset in the index-2 slot aborts the frame.
        for (int i = 0; i < 4 * R && ((n / R) % 4) != 2; i++) tick();
        check("reach_idx2", 7'((n / R) % 4), 7'd2);
        tick();
        reset = 1'b1;
        tick();
        check("midreset_an", 7'(an), 7'b0001111);
        check("midreset_fd", 7'(frame_done), 7'd0);
        reset = 1'b0;
        tick();
        check("restart_an", 7'(an), 7'b0001110);
        check("restart_seg", seg, 7'b1000000);
        run(8 * R);
        // Randomized traffic, including invalid digits and occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                hr1 = 4'($urandom_range(0, 15)); hr0 = 4'($urandom_range(0, 15));
                min1 = 4'($urandom_range(0, 15)); min0 = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 1) == 0) hr1 = 4'd0;
            end
            if ($urandom_range(0, 15) == 0) colon_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) blink_mask = 4'($urandom_range(0, 15));
            reset = ($urandom_range(0, 149) == 0);
            tick();
        end
        reset = 1'b0;
        run(4 * R);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/watch_display_scan.md
Name: watch_display_scan

Overview:
Consumer end of the watch time bus. Takes the four BCD time digits (hr1, hr0, min1, min0) produced by the watch counters and drives a 4-digit, common-anode, multiplexed seven-segment display. Scans one digit per refresh slot and latches a coherent snapshot of all four digits once per frame, so no digit tears mid-frame. Also handles hr1 leading-zero blanking, a colon, and per-digit blinking for set-time mode.

Parameters:
REFRESH_DIV, 1000, clk cycles per digit slot (>=2)
BLINK_DIV, 250000, clk cycles per blink half-period (>=2)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
hr1  input  4  hour tens digit, BCD
hr0  input  4  hour units digit, BCD
min1  input  4  minute tens digit, BCD
min0  input  4  minute units digit, BCD
colon_en  input  1  1 = light the decimal point on the hr0 digit (colon)
blink_mask  input  4  bit i = 1: digit i blinks (0=min0, 1=min1, 2=hr0, 3=hr1)
an  output  4  digit enables, active-low, an[i] selects digit i
seg  output  7  segments, active-low, {g,f,e,d,c,b,a}
dp_n  output  1  decimal point, active-low
frame_done  output  1  one-cycle pulse when a new snapshot is latched

Behaviour:
- Reset (clk edge with reset=1):
  - slot counter = 0, digit index = 0, blink counter = 0, blink_phase = 0
  - snapshot = 0000
  - an = 4'b1111, seg = 7'b1111111, dp_n = 1, frame_done = 0
- Reset mid-scan aborts the frame. The next frame starts at index 0 with the zeroed snapshot.
- Slot counter counts 0..REFRESH_DIV-1 and wraps to 0. On the wrap cycle the digit index advances 0->1->2->3->0.
- Frame boundary = wrap cycle while index = 3. On that edge:
  - snapshot <= {hr1, hr0, min1, min0} sampled that cycle
  - frame_done = 1 for exactly that following cycle
  - the inputs are not sampled at any other time
- Outputs an, seg and dp_n are registered from (index, snapshot, blink_phase, colon_en, blink_mask). They reflect a new index one cycle after the index register changes. First valid digit drive is the cycle after reset deasserts.
- Digit drive for the current index i:
  - an[i] = 0, all other an bits = 1
  - an = 4'b1111 (all off) if the digit is blanked
- Decode, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - any value 10..15 = 0111111 (dash, g only)
- Blanking (an = 1111, seg = 1111111):
  - index 3 and snapshot hr1 = 0 (leading-zero blank)
  - blink_mask[i] = 1 and blink_phase = 1
- Colon: dp_n = 0 only when index = 2, colon_en = 1 and the digit is not blanked; otherwise dp_n = 1.
- Blink counter is free-running, 0..BLINK_DIV-1. On its wrap, blink_phase toggles. blink_phase = 0 means visible.
- colon_en and blink_mask are not snapshotted; they take effect on the next output register update.
- Simultaneous frame boundary and blink toggle: both happen on the same edge, with no priority interaction.

Test Plan:
- Reset, REFRESH_DIV=4, inputs 1,2,3,4 (hr1..min0) -> first frame shows zeroed snapshot:
  - an cycles 1110, 1101, 1011, 1111 (hr1=0 blanked), seg=1000000 on the three lit digits
  - frame_done pulses one cycle after the index-3 slot ends
  - second frame shows min0=0011001, min1=0110000, hr0=0100100, hr1=1111001
- Change min0 from 4 to 5 mid-frame -> current frame still shows 0011001 on an[0]; the next frame shows 0010010.
- colon_en=1 -> dp_n=0 only while an=1011. colon_en=0 -> dp_n stays 1 for all slots.
- blink_mask=4'b0011, BLINK_DIV=8 -> digits 0 and 1 give an=1111 and seg=1111111 for alternating 8-cycle windows. Digits 2 and 3 are unaffected.
- hr0=4'hC presented at a frame boundary -> the hr0 slot shows seg=0111111.
- Assert reset during the index-2 slot -> the next cycle gives an=1111 and frame_done=0. Scan then restarts at index 0 with snapshot 0000.
